enigma_step_ctrl: RTL and testbench

Sequencing controller for the Enigma letter path. It accepts one plaintext letter at a time and applies odometer stepping, with double-step, to three rotor positions. It then time-multiplexes a single shared substitution unit through seven passes: forward rotors 0→1→2, reflector, then reverse rotors 2→1→0. The result is returned on a valid/ready output. It sits between the keyboard/UART front end and the shared rotor/reflector lookup, which already takes `data_in`/`position` style inputs.

---
 rtl/enigma_pkg.sv | 39 +++
 rtl/enigma_step_ctrl_if.sv | 42 ++++
 rtl/enigma_stepper.sv | 31 +++
 rtl/enigma_step_ctrl.sv | 122 ++++++++++++
 tb/tb_enigma_step_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma letter-path sequencing controller
// and the rotor stepping logic.
package enigma_pkg;

  localparam int ALPHA = 26;

  typedef logic [4:0] letter_t;
  typedef logic [1:0] sel_t;

  localparam letter_t ALPHA_L     = letter_t'(ALPHA);
  localparam letter_t LAST_LETTER = letter_t'(ALPHA - 1);

  localparam sel_t SEL_R0   = 2'd0;
  localparam sel_t SEL_R1   = 2'd1;
  localparam sel_t SEL_R2   = 2'd2;
  localparam sel_t SEL_REFL = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_STEP,
    S_FWD0,
    S_FWD1,
    S_FWD2,
    S_REFL,
    S_REV2,
    S_REV1,
    S_REV0,
    S_DONE
  } state_e;

  function automatic letter_t letter_inc(input letter_t v);
    return (v == LAST_LETTER) ? '0 : v + 5'd1;
  endfunction

  function automatic letter_t letter_sanitize(input letter_t v);
    return (v >= ALPHA_L) ? '0 : v;
  endfunction

endpackage

// File: rtl/enigma_step_ctrl_if.sv
// Bundle of configuration, letter in/out handshakes, rotor positions and the
// shared substitution unit connection of the Enigma sequencing controller.
interface enigma_step_ctrl_if;
  import enigma_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its data stay stable until that edge, ready may move.
  logic    cfg_load;
  letter_t cfg_pos0;
  letter_t cfg_pos1;
  letter_t cfg_pos2;
  logic    in_valid;
  logic    in_ready;
  letter_t in_letter;
  logic    out_valid;
  logic    out_ready;
  letter_t out_letter;
  logic    err;
  letter_t pos0;
  letter_t pos1;
  letter_t pos2;
  sel_t    sub_sel;
  logic    sub_dir;
  letter_t sub_data;
  letter_t sub_position;
  letter_t sub_result;

  modport master (
    output cfg_load, cfg_pos0, cfg_pos1, cfg_pos2, in_valid, in_letter,
           out_ready, sub_result,
    input  in_ready, out_valid, out_letter, err, pos0, pos1, pos2,
           sub_sel, sub_dir, sub_data, sub_position
  );

  modport slave (
    input  cfg_load, cfg_pos0, cfg_pos1, cfg_pos2, in_valid, in_letter,
           out_ready, sub_result,
    output in_ready, out_valid, out_letter, err, pos0, pos1, pos2,
           sub_sel, sub_dir, sub_data, sub_position
  );

endinterface

// File: rtl/enigma_stepper.sv
// Combinational odometer stepping of three rotors with the double-step
// anomaly; also usable for a key-preview display.
module enigma_stepper
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH0 = 16,
  parameter int unsigned NOTCH1 = 4
) (
  input  letter_t pos0_i,
  input  letter_t pos1_i,
  input  letter_t pos2_i,
  output letter_t pos0_o,
  output letter_t pos1_o,
  output letter_t pos2_o
);

  localparam letter_t N0 = letter_t'(NOTCH0);
  localparam letter_t N1 = letter_t'(NOTCH1);

  logic kick1;
  logic kick2;

  // Rotor 1 sitting on its own notch both kicks rotor 2 and advances itself.
  assign kick2  = (pos1_i == N1);
  assign kick1  = (pos0_i == N0) || kick2;

  assign pos0_o = letter_inc(pos0_i);
  assign pos1_o = kick1 ? letter_inc(pos1_i) : pos1_i;
  assign pos2_o = kick2 ? letter_inc(pos2_i) : pos2_i;

endmodule

// File: rtl/enigma_step_ctrl.sv
// Steps the rotors for each accepted letter, then walks one shared
// substitution unit through seven passes and returns the ciphered letter.
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH0 = 16,
  parameter int unsigned NOTCH1 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  enigma_step_ctrl_if.slave  bus,
  output state_e             dbg_state_o
);

  state_e  state_q, state_d;
  letter_t pos0_q, pos1_q, pos2_q;
  letter_t step0, step1, step2;
  letter_t work_q;
  letter_t out_letter_q;
  logic    err_q;

  logic    accept;
  logic    legal;
  logic    pass;
  sel_t    sel;
  logic    dir;
  letter_t sel_pos;

  enigma_stepper #(
    .NOTCH0 (NOTCH0),
    .NOTCH1 (NOTCH1)
  ) u_stepper (
    .pos0_i (pos0_q),
    .pos1_i (pos1_q),
    .pos2_i (pos2_q),
    .pos0_o (step0),
    .pos1_o (step1),
    .pos2_o (step2)
  );

  // A simultaneous configuration load takes priority over the offered letter.
  assign accept = (state_q == S_IDLE) && bus.in_valid && !bus.cfg_load;
  assign legal  = (bus.in_letter < ALPHA_L);

  always_comb begin
    state_d = state_q;
    pass    = 1'b0;
    sel     = SEL_R0;
    dir     = 1'b0;
    case (state_q)
      S_IDLE: if (accept && legal) state_d = S_STEP;
      S_STEP: state_d = S_FWD0;
      S_FWD0: begin pass = 1'b1; sel = SEL_R0;   state_d = S_FWD1; end
      S_FWD1: begin pass = 1'b1; sel = SEL_R1;   state_d = S_FWD2; end
      S_FWD2: begin pass = 1'b1; sel = SEL_R2;   state_d = S_REFL; end
      S_REFL: begin pass = 1'b1; sel = SEL_REFL; state_d = S_REV2; end
      S_REV2: begin pass = 1'b1; sel = SEL_R2; dir = 1'b1; state_d = S_REV1; end
      S_REV1: begin pass = 1'b1; sel = SEL_R1; dir = 1'b1; state_d = S_REV0; end
      S_REV0: begin pass = 1'b1; sel = SEL_R0; dir = 1'b1; state_d = S_DONE; end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_pos = '0;
    if (pass) begin
      case (sel)
        SEL_R0:  sel_pos = pos0_q;
        SEL_R1:  sel_pos = pos1_q;
        SEL_R2:  sel_pos = pos2_q;
        default: sel_pos = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pos0_q       <= '0;
      pos1_q       <= '0;
      pos2_q       <= '0;
      work_q       <= '0;
      out_letter_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !legal;
      if ((state_q == S_IDLE) && bus.cfg_load) begin
        pos0_q <= letter_sanitize(bus.cfg_pos0);
        pos1_q <= letter_sanitize(bus.cfg_pos1);
        pos2_q <= letter_sanitize(bus.cfg_pos2);
      end else if (state_q == S_STEP) begin
        pos0_q <= step0;
        pos1_q <= step1;
        pos2_q <= step2;
      end
      if (accept && legal) begin
        work_q <= bus.in_letter;
      end else if (pass) begin
        work_q <= bus.sub_result;
      end
      if (state_q == S_REV0) begin
        out_letter_q <= bus.sub_result;
      end
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE) && rst_n;
  assign bus.out_valid    = (state_q == S_DONE);
  assign bus.out_letter   = out_letter_q;
  assign bus.err          = err_q;
  assign bus.pos0         = pos0_q;
  assign bus.pos1         = pos1_q;
  assign bus.pos2         = pos2_q;
  assign bus.sub_sel      = sel;
  assign bus.sub_dir      = dir;
  assign bus.sub_data     = pass ? work_q : '0;
  assign bus.sub_position = sel_pos;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Bench for enigma_step_ctrl: transaction-level Enigma model with per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_enigma_step_ctrl;
  import enigma_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  enigma_step_ctrl_if bus();

  enigma_step_ctrl #(
    .NOTCH0 (16),
    .NOTCH1 (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Shared substitution unit stand-in.
  assign bus.sub_result = 5'((int'(bus.sub_data) + int'(bus.sub_position)
                              + int'(bus.sub_sel) + 1) % 26);

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  localparam int PASS_SEL [7] = '{0, 1, 2, 3, 2, 1, 0};
  localparam int PASS_DIR [7] = '{0, 0, 0, 0, 1, 1, 1};

  // Model state: m_age counts clock edges since the letter was accepted.
  int          m_pos [3] = '{0, 0, 0};
  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_letter = 0;
  int          m_trace [7] = '{0, 0, 0, 0, 0, 0, 0};
  int          m_result = 0;
  int          m_out_letter = 0;
  bit          m_err = 1'b0;
  logic [4:0]  exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic int inc26(input int v);
    return (v + 1) % 26;
  endfunction

  // Enigma reference: odometer step with double step, then seven lookups.
  task automatic model_step_and_cipher();
    int p0, p1, p2, d, p;
    p0 = m_pos[0]; p1 = m_pos[1]; p2 = m_pos[2];
    m_pos[0] = inc26(p0);
    if (p0 == 16 || p1 == 4) m_pos[1] = inc26(p1);
    if (p1 == 4) m_pos[2] = inc26(p2);
    d = m_letter;
    for (int k = 0; k < 7; k++) begin
      m_trace[k] = d;
      p = (PASS_SEL[k] == 3) ? 0 : m_pos[PASS_SEL[k]];
      d = (d + p + PASS_SEL[k] + 1) % 26;
    end
    m_result = d;
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b0; m_age = 0; m_pos = '{0, 0, 0};
      m_out_letter = 0; m_err = 1'b0; exp_q.delete();
    end else begin
      m_err = 1'b0;
      if (!m_busy) begin
        if (bus.cfg_load) begin
          m_pos[0] = (bus.cfg_pos0 < 26) ? int'(bus.cfg_pos0) : 0;
          m_pos[1] = (bus.cfg_pos1 < 26) ? int'(bus.cfg_pos1) : 0;
          m_pos[2] = (bus.cfg_pos2 < 26) ? int'(bus.cfg_pos2) : 0;
        end else if (bus.in_valid) begin
          if (bus.in_letter < 26) begin
            m_busy = 1'b1; m_age = 1; m_letter = int'(bus.in_letter);
          end else begin
            m_err = 1'b1;
          end
        end
      end else if (m_age == 1) begin
        model_step_and_cipher();
        m_age = 2;
      end else if (m_age < 9) begin
        m_age++;
        if (m_age == 9) begin
          m_out_letter = m_result;
          exp_q.push_back(5'(m_result));
        end
      end else if (bus.out_ready) begin
        m_busy = 1'b0; m_age = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("in_ready", 32'(bus.in_ready), int'(!m_busy && rst_n));
      check("out_valid", 32'(bus.out_valid), int'(m_busy && m_age >= 9));
      check("out_letter", 32'(bus.out_letter), m_out_letter);
      check("err", 32'(bus.err), int'(m_err));
      check("pos0", 32'(bus.pos0), m_pos[0]);
      check("pos1", 32'(bus.pos1), m_pos[1]);
      check("pos2", 32'(bus.pos2), m_pos[2]);
      if (m_busy && m_age >= 2 && m_age <= 8) begin
        int k;
        k = m_age - 2;
        check("sub_sel", 32'(bus.sub_sel), PASS_SEL[k]);
        check("sub_dir", 32'(bus.sub_dir), PASS_DIR[k]);
        check("sub_position", 32'(bus.sub_position),
              (PASS_SEL[k] == 3) ? 0 : m_pos[PASS_SEL[k]]);
        check("sub_data", 32'(bus.sub_data), m_trace[k]);
      end else begin
        check("sub_sel_idle", 32'(bus.sub_sel), 0);
        check("sub_dir_idle", 32'(bus.sub_dir), 0);
        check("sub_position_idle", 32'(bus.sub_position), 0);
        check("sub_data_idle", 32'(bus.sub_data), 0);
      end
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) fail_now("sb_unexpected_out");
        else check("sb_letter", 32'(bus.out_letter), int'(exp_q[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int p0, input int p1, input int p2);
    bus.cfg_load = 1'b1;
    bus.cfg_pos0 = 5'(p0); bus.cfg_pos1 = 5'(p1); bus.cfg_pos2 = 5'(p2);
    tick();
    bus.cfg_load = 1'b0;
  endtask

  task automatic send(input int l);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_letter = 5'(l);
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = bus.in_ready && !bus.cfg_load;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.out_valid) fail_now("wait_out_timeout");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.in_ready) fail_now("wait_idle_timeout");
  endtask

  task automatic check_pos(input string name, input int p0, input int p1, input int p2);
    check({name, "_p0"}, 32'(bus.pos0), p0);
    check({name, "_p1"}, 32'(bus.pos1), p1);
    check({name, "_p2"}, 32'(bus.pos2), p2);
  endtask

  initial begin
    int lat;
    int held;
    int exp_trace [7];
    exp_trace = '{0, 2, 4, 7, 11, 14, 16};
    bus.cfg_load = 1'b0;
    bus.cfg_pos0 = '0; bus.cfg_pos1 = '0; bus.cfg_pos2 = '0;
    bus.in_valid = 1'b0; bus.in_letter = '0; bus.out_ready = 1'b1;

    @(posedge clk);
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check_pos("rst", 0, 0, 0);

    // Basic path from 0/0/0 with letter 0.
    send(0);
    wait_out(lat);
    check("basic_latency", 32'(lat), 8);
    check("basic_out", 32'(bus.out_letter), 18);
    check_pos("basic", 1, 0, 0);
    for (int k = 0; k < 7; k++) check("model_trace", 32'(m_trace[k]), exp_trace[k]);
    check("model_result", 32'(m_result), 18);
    wait_idle();

    load(16, 0, 0);
    send(5);
    wait_out(lat);
    check_pos("carry", 17, 1, 0);
    wait_idle();

    load(5, 4, 9);
    send(11);
    wait_out(lat);
    check_pos("dbl1", 6, 5, 10);
    wait_idle();
    send(12);
    wait_out(lat);
    check_pos("dbl2", 7, 5, 10);
    wait_idle();

    load(25, 25, 25);
    send(25);
    wait_out(lat);
    check_pos("wrap", 0, 25, 25);
    wait_idle();

    // Back-pressure on the output while a second letter waits.
    bus.out_ready = 1'b0;
    send(3);
    wait_out(lat);
    held = int'(bus.out_letter);
    bus.in_valid = 1'b1;
    bus.in_letter = 5'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hs_hold_letter", 32'(bus.out_letter), held);
      check("hs_hold_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("hs_idle_after", 32'(bus.in_ready), 1);
    tick();
    check("hs_accepted", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    wait_out(lat);
    wait_idle();

    load(3, 7, 11);
    bus.in_valid = 1'b1;
    bus.in_letter = 5'd28;
    tick();
    bus.in_valid = 1'b0;
    check("err_pulse", 32'(bus.err), 1);
    tick();
    check("err_gone", 32'(bus.err), 0);
    check("err_no_accept", 32'(bus.in_ready), 1);
    check_pos("err", 3, 7, 11);

    load(0, 0, 0);
    send(1);
    tick();
    tick();
    check("fwd1_state", 32'(dbg_state), int'(S_FWD1));
    bus.cfg_load = 1'b1;
    bus.cfg_pos0 = 5'd9; bus.cfg_pos1 = 5'd9; bus.cfg_pos2 = 5'd9;
    tick();
    bus.cfg_load = 1'b0;
    wait_out(lat);
    check_pos("cfg_ignored", 1, 0, 0);
    wait_idle();

    load(4, 4, 4);
    send(2);
    repeat (4) tick();
    check("refl_state", 32'(dbg_state), int'(S_REFL));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_state", 32'(dbg_state), int'(S_IDLE));
    check("mid_rst_ready", 32'(bus.in_ready), 1);
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check_pos("mid_rst", 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("mid_rst_no_out", 32'(bus.out_valid), 0);
    end

    for (int i = 0; i < 700; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_letter = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31))
                                                  : 5'($urandom_range(0, 25));
      bus.cfg_load  = ($urandom_range(0, 15) == 0);
      bus.cfg_pos0  = 5'($urandom_range(0, 31));
      bus.cfg_pos1  = 5'($urandom_range(0, 31));
      bus.cfg_pos2  = 5'($urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rst_n         = ($urandom_range(0, 149) != 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.cfg_load = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
